jtvigil_palload: RTL and testbench
==================================

# jtvigil_palload

Palette upload engine for the Vigilante video path. It takes packed 15-bit colours from a byte stream (ioctl download, save-state restore or debug injector) and writes them into the 2 kB palette RAM. The RAM layout it produces is the one the colour mixer scans: address = {bank, component[1:0], index[7:0]}, with components R=0, G=1, B=2 and data in bits [4:0]. The block drives the RAM's write-side port. Arbitration with the main CPU is handled outside this block, using `busy`.

## Interface
Parameters:
- ENTRIES, 512, number of colours written per upload. Must be a power of two, 2..512. Entry counter bit 8 is the bank bit; bits [7:0] are the index.

Ports:
- clk  in  1  video/system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an upload; sampled only in IDLE.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  block accepts byte_in this cycle.
- pal_addr  out  11  palette RAM write address.
- pal_dout  out  8  palette RAM write data.
- pal_we  out  1  palette RAM write strobe, one cycle per write.
- busy  out  1  an upload is in progress.
- done  out  1  one-cycle pulse when the last entry has been written.

## Operation
- Stream format per colour is two bytes, little-endian word xBBBBBGGGGGRRRRR:
  - First byte: G[2:0], R[4:0].
  - Second byte: x, B[4:0], G[4:3].
- Bit 15 is ignored.
- FSM states: IDLE, LO, HI, WR_R, WR_G, WR_B, DONE.
  - IDLE: busy=0, byte_ready=0. start=1 → LO, entry counter cleared to 0.
  - LO: byte_ready=1. On byte_valid, latch byte → HI.
  - HI: byte_ready=1. On byte_valid, latch byte → WR_R.
  - WR_R: pal_we=1, addr={entry[8],2'd0,entry[7:0]}, data={3'b0,R} → WR_G.
  - WR_G: pal_we=1, component 1, data={3'b0,G[4:0]} → WR_B.
  - WR_B: pal_we=1, component 2, data={3'b0,B} → DONE if entry==ENTRIES-1, else entry+1 and → LO.
  - DONE: done=1, busy=1 → IDLE.
- busy=1 in every state except IDLE.
- For ENTRIES<512, unused high bits of entry read as 0. Bank bit = entry[8] only when ENTRIES=512.
- The component-3 region (offsets 0x300–0x3FF within each bank) is never written.
- byte_valid while byte_ready=0 is ignored. No byte is consumed in IDLE, WR_* or DONE.
- start while not in IDLE is ignored. This includes the DONE cycle; a new upload needs start again after busy falls.
- Entry counter width is 9 bits. It is never allowed to wrap; termination is by compare.

## Timing
- Reset values: FSM=IDLE, entry=0, byte_ready=0, pal_we=0, pal_addr=0, pal_dout=0, busy=0, done=0.
- Outputs are registered or decoded from the registered state. byte_ready is a state decode, not combinational on byte_valid.
- Minimum cycles per colour is 5 (LO, HI, three writes), when byte_valid is held high.
- Full 512-entry upload with continuous stream: start at cycle 0.
  - busy high from cycle 1.
  - Last write at cycle 2560.
  - done at cycle 2561.
  - busy low at cycle 2562.
- A stalled stream (byte_valid=0) holds LO/HI indefinitely with no timeout.
- Reset mid-upload: immediate return to reset values. RAM contents already written stay as they are; no rollback.
- pal_addr/pal_dout hold their last values outside WR_* states. Only pal_we qualifies them.

## Test plan
- Reset, then idle 10 cycles → busy=0, byte_ready=0, pal_we=0, done=0, pal_addr=0.
- ENTRIES=512, start, stream 0x1F,0x00 (entry 0) then zeros → writes (0x000,0x1F), (0x100,0x00), (0x200,0x00).
  - Entry 300 = 0xE0,0x7F → writes (0x42C,0x00), (0x52C,0x1F), (0x62C,0x1F).
  - done pulses exactly once at cycle 2561.
- Random byte_valid gaps (50% duty) over a full upload → RAM model matches the expected R/G/B per entry. No pal_we during LO/HI. Exactly 1536 writes.
- Pulse start at cycles 5, 100 and on the DONE cycle → no restart, no extra writes, busy falls on schedule.
- Assert rst in WR_G of entry 7 → outputs at reset values in the same cycle. Entry 7 R was written; G and B were not. Next start begins again at entry 0.
- ENTRIES=16 → 48 writes, last at addr 0x20F, done after entry 15. Bank bit is always 0.

Source files
------------

// File: rtl/jtvigil_palload.sv
// Palette upload engine: unpacks little-endian xBBBBBGGGGGRRRRR words from a byte
// stream and writes R/G/B as three 5-bit entries into the mixer's palette RAM layout.
module jtvigil_palload #(
    parameter int ENTRIES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [10:0] pal_addr,
    output logic [7:0]  pal_dout,
    output logic        pal_we,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start, no bytes consumed
    // LO    | waiting for first byte (G[2:0], R)
    // HI    | waiting for second byte (x, B, G[4:3])
    // WR_R  | writing red component
    // WR_G  | writing green component
    // WR_B  | writing blue component, then next entry or finish
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WR_R = 3'd3,
        WR_G = 3'd4,
        WR_B = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [8:0] LAST = 9'(ENTRIES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [8:0] entry;
    logic [7:0] lo_q;
    logic [6:0] hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = LO;
            LO:      if (byte_valid) state_nxt = HI;
            HI:      if (byte_valid) state_nxt = WR_R;
            WR_R:    state_nxt = WR_G;
            WR_G:    state_nxt = WR_B;
            WR_B:    state_nxt = (entry == LAST) ? DONE : LO;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == LO) || (state == HI);
        pal_we     = (state == WR_R) || (state == WR_G) || (state == WR_B);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    // Address/data are loaded one cycle ahead of each write state so that the
    // RAM port sees registered values; they hold outside the write states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            pal_addr <= '0;
            pal_dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) entry <= '0;
                end
                LO: begin
                    if (byte_valid) lo_q <= byte_in;
                end
                HI: begin
                    if (byte_valid) begin
                        hi_q     <= byte_in[6:0];
                        pal_addr <= {entry[8], 2'd0, entry[7:0]};
                        pal_dout <= {3'b000, lo_q[4:0]};
                    end
                end
                WR_R: begin
                    pal_addr <= {entry[8], 2'd1, entry[7:0]};
                    pal_dout <= {3'b000, hi_q[1:0], lo_q[7:5]};
                end
                WR_G: begin
                    pal_addr <= {entry[8], 2'd2, entry[7:0]};
                    pal_dout <= {3'b000, hi_q[6:2]};
                end
                WR_B: begin
                    // termination is by compare, so the counter never wraps
                    if (entry != LAST) entry <= entry + 9'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtvigil_palload.sv
// Directed bench for jtvigil_palload: full 512-entry uploads, stalls, ignored
// start pulses, mid-upload reset, and a 16-entry instance.
module tb_jtvigil_palload;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start16 = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, byte_ready16;
    logic [10:0] pal_addr, pal_addr16;
    logic [7:0]  pal_dout, pal_dout16;
    logic        pal_we, pal_we16;
    logic        busy, busy16;
    logic        done, done16;

    jtvigil_palload #(.ENTRIES(512)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .pal_addr(pal_addr),
        .pal_dout(pal_dout), .pal_we(pal_we), .busy(busy), .done(done)
    );

    jtvigil_palload #(.ENTRIES(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready16), .pal_addr(pal_addr16),
        .pal_dout(pal_dout16), .pal_we(pal_we16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // mode 1: entry 0 = 0x001F, entry 300 = 0x7FE0, others 0; mode 2: hashed colours
    function automatic logic [15:0] col(input int mode, input int e);
        logic [15:0] ev;
        ev = 16'(e);
        if (mode == 1) return (e == 0) ? 16'h001F : (e == 300) ? 16'h7FE0 : 16'h0000;
        return (ev * 16'h02F3) ^ 16'h5A5A;
    endfunction

    function automatic logic [7:0] byte_of(input int mode, input int idx);
        logic [15:0] c;
        c = col(mode, idx / 2);
        return (idx % 2 == 1) ? c[15:8] : c[7:0];
    endfunction

    // write monitors
    logic [7:0]  mem   [2048];
    logic [7:0]  mem16 [2048];
    int nwr, ndone, done_cyc, last_wr, busy_rise, busy_fall, bad3, badlh;
    int first_cyc;
    logic [10:0] first_addr;
    logic [7:0]  first_data;
    bit          got_first, busy_q;
    int nwr16, ndone16, done_cyc16, bank16;
    logic [10:0] last_addr16;
    logic [7:0]  last_data16;

    task automatic clear_mon();
        for (int i = 0; i < 2048; i++) begin
            mem[i]   = 8'hAA;
            mem16[i] = 8'hAA;
        end
        nwr = 0; ndone = 0; done_cyc = -1; last_wr = -1; busy_rise = -1; busy_fall = -1;
        bad3 = 0; badlh = 0; got_first = 0; first_cyc = -1; first_addr = '0; first_data = '0;
        busy_q = 0;
        nwr16 = 0; ndone16 = 0; done_cyc16 = -1; bank16 = 0; last_addr16 = '0; last_data16 = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pal_we) begin
                mem[pal_addr] = pal_dout;
                nwr++;
                last_wr = cyc - t0;
                if (pal_addr[9:8] == 2'd3) bad3++;
                if (byte_ready) badlh++;
                if (!got_first) begin
                    got_first  = 1;
                    first_addr = pal_addr;
                    first_data = pal_dout;
                    first_cyc  = cyc - t0;
                end
            end
            if (done) begin
                ndone++;
                done_cyc = cyc - t0;
            end
            if (!busy_q && busy) busy_rise = cyc - t0;
            if (busy_q && !busy) busy_fall = cyc - t0;
            busy_q = busy;
            if (pal_we16) begin
                mem16[pal_addr16] = pal_dout16;
                nwr16++;
                last_addr16 = pal_addr16;
                last_data16 = pal_dout16;
                if (pal_addr16[10]) bank16++;
            end
            if (done16) begin
                ndone16++;
                done_cyc16 = cyc - t0;
            end
        end
    end

    task automatic send_stream(input int mode, input int n, input bit gaps, input bit sel,
                               output bit ok);
        bit rdy;
        int guard;
        ok = 1;
        for (int idx = 0; idx < 2 * n; idx++) begin
            byte_in = byte_of(mode, idx);
            guard = 0;
            forever begin
                byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                rdy = sel ? byte_ready16 : byte_ready;
                @(posedge clk);
                #1;
                if (rst) begin
                    byte_valid = 1'b0;
                    return;
                end
                if (byte_valid && rdy) break;
                guard++;
                if (guard > 400) begin
                    ok = 0;
                    byte_valid = 1'b0;
                    return;
                end
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic kick(input bit sel);
        @(posedge clk);
        #1;
        if (sel) start16 = 1'b1; else start = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_done(input bit sel, input int limit);
        int k = 0;
        while (((sel ? ndone16 : ndone) == 0) && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk(sel ? "done16_seen" : "done_seen", 32'(sel ? ndone16 : ndone), 32'd1);
        repeat (20) @(posedge clk);
    endtask

    task automatic check_mem(input string tag, input int mode, input int n, input bit sel);
        int errs = 0;
        logic [15:0] c;
        logic [8:0]  e9;
        logic [10:0] a;
        for (int e = 0; e < n; e++) begin
            c  = col(mode, e);
            e9 = 9'(e);
            a  = {e9[8], 2'd0, e9[7:0]};
            if ((sel ? mem16[a] : mem[a]) !== {3'b0, c[4:0]}) errs++;
            a  = {e9[8], 2'd1, e9[7:0]};
            if ((sel ? mem16[a] : mem[a]) !== {3'b0, c[9:5]}) errs++;
            a  = {e9[8], 2'd2, e9[7:0]};
            if ((sel ? mem16[a] : mem[a]) !== {3'b0, c[14:10]}) errs++;
        end
        chk(tag, 32'(errs), 32'd0);
    endtask

    bit ok;

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("idle_we", 32'(pal_we), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_addr", 32'(pal_addr), 32'd0);
        chk("idle_dout", 32'(pal_dout), 32'd0);

        // continuous upload, with stray start pulses at cycles 5, 100 and on DONE
        clear_mon();
        kick(0);
        fork
            send_stream(1, 512, 0, 0, ok);
            begin
                @(posedge clk); #1 start = 1'b0;
                repeat (4) @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                repeat (94) @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                repeat (2460) @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        chk("stream1_ok", 32'(ok), 32'd1);
        wait_done(0, 3000);
        chk("e0_r", 32'(mem[11'h000]), 32'h1F);
        chk("e0_g", 32'(mem[11'h100]), 32'h00);
        chk("e0_b", 32'(mem[11'h200]), 32'h00);
        chk("e300_r", 32'(mem[11'h42C]), 32'h00);
        chk("e300_g", 32'(mem[11'h52C]), 32'h1F);
        chk("e300_b", 32'(mem[11'h62C]), 32'h1F);
        check_mem("mem_mode1", 1, 512, 0);
        chk("first_addr", 32'(first_addr), 32'h000);
        chk("first_cyc", 32'(first_cyc), 32'd3);
        chk("busy_rise", 32'(busy_rise), 32'd1);
        chk("last_wr", 32'(last_wr), 32'd2560);
        chk("done_cyc", 32'(done_cyc), 32'd2561);
        chk("done_count", 32'(ndone), 32'd1);
        chk("busy_fall", 32'(busy_fall), 32'd2562);
        chk("writes1", 32'(nwr), 32'd1536);
        chk("busy_after", 32'(busy), 32'd0);
        chk("comp3_1", 32'(bad3), 32'd0);

        // 50% duty stream
        clear_mon();
        kick(0);
        @(posedge clk); #1 start = 1'b0;
        send_stream(2, 512, 1, 0, ok);
        chk("stream2_ok", 32'(ok), 32'd1);
        wait_done(0, 3000);
        check_mem("mem_mode2_gaps", 2, 512, 0);
        chk("writes2", 32'(nwr), 32'd1536);
        chk("we_in_lohi", 32'(badlh), 32'd0);
        chk("comp3_2", 32'(bad3), 32'd0);

        // reset during WR_G of entry 7 (cycle 3 + 5*7 + 1 = 39)
        clear_mon();
        kick(0);
        fork
            send_stream(2, 512, 0, 0, ok);
            begin
                @(posedge clk); #1 start = 1'b0;
                repeat (38) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_we", 32'(pal_we), 32'd0);
                chk("rst_addr", 32'(pal_addr), 32'd0);
                chk("rst_dout", 32'(pal_dout), 32'd0);
                chk("rst_ready", 32'(byte_ready), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end
        join
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_e7_r", 32'(mem[11'h007]), 32'h1F);
        chk("rst_e7_g", 32'(mem[11'h107]), 32'hAA);
        chk("rst_e7_b", 32'(mem[11'h207]), 32'hAA);
        chk("rst_writes", 32'(nwr), 32'd22);

        // restart begins at entry 0
        clear_mon();
        kick(0);
        fork
            send_stream(2, 512, 0, 0, ok);
            begin
                @(posedge clk); #1 start = 1'b0;
                repeat (3) @(posedge clk);
                #2 rst = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("restart_addr", 32'(first_addr), 32'h000);
        chk("restart_data", 32'(first_data), 32'h1A);
        chk("restart_cyc", 32'(first_cyc), 32'd3);

        // 16-entry instance
        clear_mon();
        kick(1);
        @(posedge clk); #1 start16 = 1'b0;
        send_stream(2, 16, 0, 1, ok);
        chk("stream16_ok", 32'(ok), 32'd1);
        wait_done(1, 200);
        chk("writes16", 32'(nwr16), 32'd48);
        chk("last_addr16", 32'(last_addr16), 32'h20F);
        chk("last_data16", 32'(last_data16), 32'({3'b0, col(2, 15)} >> 10) & 32'h1F);
        chk("done_cyc16", 32'(done_cyc16), 32'd81);
        chk("bank16", 32'(bank16), 32'd0);
        chk("dut512_quiet", 32'(nwr), 32'd0);
        check_mem("mem16", 2, 16, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
